uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, giving i_Clk cycles per UART bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 The module SHALL have port i_Clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port i_Rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port i_UART_RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The module SHALL have port i_RX_Ready  input  1  consumer accepts the held byte when high together with o_RX_Valid.
REQ-006 The module SHALL have port o_RX_Valid  output  1  the holding register contains an unconsumed byte.
REQ-007 The module SHALL have port o_RX_Byte  output  8  the received data byte; stable while o_RX_Valid is high.
REQ-008 The module SHALL have port o_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 The module SHALL have port o_Overrun  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.
REQ-010 The module SHALL have port o_Busy  output  1  high in every state except IDLE.

Function
REQ-011 i_UART_RX SHALL pass through a two-flop synchronizer; the first synchronizer flop feeds the second, and only the second flop's output (rx_s) is used; both flops reset to 1.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH, with a bit-cycle counter (16 bits) and a bit index (3 bits).
REQ-013 In IDLE, rx_s == 0 SHALL move the FSM to START and clear the counter.
REQ-014 In START, when the counter reaches (CLKS_PER_BIT-1)/2 (integer division), the FSM SHALL go to DATA with index 0 if rx_s == 0; otherwise it SHALL return to IDLE (glitch rejected, no flag).
REQ-015 In DATA, each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1, after which the counter clears; the bit is stored at the current index, and after index 7 the FSM goes to STOP.
REQ-016 In STOP, rx_s SHALL be sampled at counter CLKS_PER_BIT-1: a 1 delivers the byte (REQ-018) and moves the FSM to IDLE; a 0 pulses o_Frame_Err for one cycle, discards the byte and moves the FSM to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL stay until rx_s == 1, then go to IDLE; a break condition therefore produces exactly one o_Frame_Err.
REQ-018 Delivery SHALL load o_RX_Byte and set o_RX_Valid on the clock edge following the stop-sample cycle.
REQ-019 o_RX_Valid SHALL clear on the edge after a cycle in which o_RX_Valid && i_RX_Ready, unless a delivery occurs in that same cycle.
REQ-020 If a delivery and an acceptance occur in the same cycle, the new byte SHALL load and o_RX_Valid SHALL remain high.
REQ-021 If a delivery occurs while o_RX_Valid is high and i_RX_Ready is low, the new byte SHALL be dropped, o_RX_Byte SHALL be kept, and o_Overrun SHALL pulse for one cycle.
REQ-022 A new start bit SHALL be recognised in the first IDLE cycle after STOP, so back-to-back frames are received without loss.
REQ-023 Latency from the line falling edge to o_RX_Valid SHALL be 2 + (CLKS_PER_BIT-1)/2 + 1 + 9*CLKS_PER_BIT + 1 cycles, within ±1 cycle.

Reset
REQ-024 While i_Rst is high at a clock edge, the FSM SHALL go to IDLE, the counter and index SHALL clear, and the synchronizer SHALL be set to 1.
REQ-025 While i_Rst is high at a clock edge, o_RX_Valid, o_Frame_Err, o_Overrun and o_Busy SHALL be 0 and o_RX_Byte SHALL be 8'h00.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no pulse on any flag.
REQ-027 After reset, if the line is low, the next byte is taken from the first falling edge seen after the synchronizer updates; a line held low through reset SHALL be treated as a start bit.

Verification (CLKS_PER_BIT=8)
REQ-028 The bench SHALL cover: frame 0xA5 with i_RX_Ready=1 -> o_RX_Valid for 1 cycle, o_RX_Byte=8'hA5, no flags.
REQ-029 The bench SHALL cover: frames 0x3C then 0xC3 back-to-back with i_RX_Ready=0 -> o_RX_Byte stays 8'h3C, o_Overrun pulses once at the second stop sample; raising i_RX_Ready then clears o_RX_Valid.
REQ-030 The bench SHALL cover: frame 0x55 with stop bit 0 followed by 20 low bit-times -> exactly one o_Frame_Err, o_RX_Valid stays 0, and the next valid 0x0F is received correctly.
REQ-031 The bench SHALL cover: a 3-cycle low glitch on an idle line -> START, then IDLE, no output and no flag.
REQ-032 The bench SHALL cover: i_Rst asserted during data bit 4 of 0xFF -> all outputs 0, o_Busy=0, and the following 0x81 is received correctly.
REQ-033 The bench SHALL cover: a delivery in the same cycle as i_RX_Ready acceptance -> o_RX_Valid stays high with the new byte and no o_Overrun.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with a one-byte holding register and a
// valid/ready handshake towards the consumer.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_UART_RX,
    input  logic       i_RX_Ready,
    output logic       o_RX_Valid,
    output logic [7:0] o_RX_Byte,
    output logic       o_Frame_Err,
    output logic       o_Overrun,
    output logic       o_Busy
);

    // Last counter value of a full bit, and the mid-point of the start bit.
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      state_q, state_d;
    logic        rx_m_q, rx_m_d;
    logic        rx_s_q, rx_s_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic [7:0]  byte_q, byte_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic        bit_end;
    logic        half_hit;
    logic        deliver;
    logic        accept;

    assign bit_end  = (cnt_q == BIT_LAST);
    assign half_hit = (cnt_q == HALF_BIT);
    assign accept   = valid_q && i_RX_Ready;

    // State register plus all datapath flops; reset returns to an idle, high line.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            rx_m_q  <= rx_m_d;
            rx_s_q  <= rx_s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic: a start bit must still be low at its mid-point, and a
    // low stop bit parks the FSM until the line returns high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s_q) state_d = S_START;
            S_START:     if (half_hit) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:      if (bit_end && (idx_q == 3'd7)) state_d = S_STOP;
            S_STOP:      if (bit_end) state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath and outputs: bit timing, sampling, delivery into the holding register.
    always_comb begin
        rx_m_d  = i_UART_RX;
        rx_s_d  = rx_m_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: cnt_d = '0;
            S_START: begin
                if (half_hit) begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    deliver = rx_s_q;
                    ferr_d  = !rx_s_q;
                end
            end
            default: cnt_d = '0;
        endcase

        // A byte lands if the register is empty or being emptied this cycle.
        valid_d = valid_q;
        byte_d  = byte_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || accept) begin
                byte_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    assign o_RX_Valid  = valid_q;
    assign o_RX_Byte   = byte_q;
    assign o_Frame_Err = ferr_q;
    assign o_Overrun   = ovr_q;
    assign o_Busy      = (state_q != S_IDLE);

endmodule
